// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed register memory, with a fixed
// number of wait states per transfer and PSLVERR on bad addresses.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_latch;
  logic                  w_pready;
  logic                  w_err;
  logic [IDX_W-1:0]      w_idx;

  assign w_idx = r_addr[IDX_W+1:2];
  assign w_err = (paddr[1:0] != 2'b00) || ({1'b0, paddr} >= LIMIT);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pready    = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (psel && !penable) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = WS;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel) begin
          w_state_nxt = IDLE;
        end else if (r_cnt != 4'd0) begin
          if (penable) w_cnt_nxt = r_cnt - 4'd1;
        end else if (penable) begin
          w_pready    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Address, direction and data are captured only in the setup phase, so
  // bus changes during ACCESS have no effect.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else if (w_latch) begin
      r_addr  <= paddr;
      r_write <= pwrite;
      r_wdata <= pwdata;
      r_err   <= w_err;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_pready && r_write && !r_err) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  always_comb begin
    pready  = w_pready;
    pslverr = w_pready && r_err;
    prdata  = '0;
    if (w_pready && !r_write && !r_err) prdata = r_mem[w_idx];
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances cover WAIT_STATES 1, 2, 0.
module tb_apb_slave_mem;

  logic        clk;
  logic        resetn;
  logic [2:0]  psel_v;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata_v [3];
  logic        pready_v [3];
  logic        pslverr_v [3];

  int checks;
  int errors;

  logic [31:0] rd;
  logic        er;
  int          cy;

  apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .resetn(resetn), .psel(psel_v[0]), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]),
    .pslverr(pslverr_v[0])
  );

  apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .resetn(resetn), .psel(psel_v[1]), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]),
    .pslverr(pslverr_v[1])
  );

  apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .resetn(resetn), .psel(psel_v[2]), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]),
    .pslverr(pslverr_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete transfer on instance d; returns after sampling the
  // completion cycle, leaving psel/penable high so the next call is back-to-back.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int cycles);
    @(posedge clk); #1;
    psel_v    = '0;
    psel_v[d] = 1'b1;
    penable   = 1'b0;
    paddr     = addr;
    pwrite    = wr;
    pwdata    = wdata;
    cycles    = 1;
    @(posedge clk); #1;
    penable = 1'b1;
    cycles  = 2;
    rdata   = '0;
    err     = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #4;
      if (pready_v[d]) begin
        rdata = prdata_v[d];
        err   = pslverr_v[d];
        return;
      end
      checks++;
      if (prdata_v[d] !== 32'h0 || pslverr_v[d] !== 1'b0) begin
        errors++;
        $display("FAIL wait_outputs dut%0d got prdata=%h pslverr=%b exp prdata=0 pslverr=0",
                 d, prdata_v[d], pslverr_v[d]);
      end
      paddr  = ~addr;
      pwdata = ~wdata;
      @(posedge clk); #1;
      cycles++;
    end
    checks++;
    errors++;
    $display("FAIL xfer_timeout dut%0d addr=%h got no pready exp pready within 40 cycles", d, addr);
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    psel_v  = '0;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    psel_v  = '0;
    penable = 1'b0;
    paddr   = '0;
    pwrite  = 1'b0;
    pwdata  = '0;
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (pready_v[d] !== 1'b0 || pslverr_v[d] !== 1'b0 || prdata_v[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got %b/%b/%h exp 0/0/00000000",
                 d, pready_v[d], pslverr_v[d], prdata_v[d]);
      end
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, cy);
    checks++;
    if (er !== 1'b0 || cy !== 3) begin
      errors++;
      $display("FAIL basic_write got err=%b cycles=%0d exp err=0 cycles=3", er, cy);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, rd, er, cy);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || cy !== 3) begin
      errors++;
      $display("FAIL basic_read got %h err=%b cycles=%0d exp deadbeef err=0 cycles=3", rd, er, cy);
    end
    bus_idle();
  endtask

  task automatic test_range();
    xfer(0, 1'b0, 32'h400, 32'h0, rd, er, cy);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      errors++;
      $display("FAIL range_read got %h err=%b exp 00000000 err=1", rd, er);
    end
    xfer(0, 1'b1, 32'h400, 32'h77777777, rd, er, cy);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL range_write got err=%b exp err=1", er);
    end
    xfer(0, 1'b0, 32'h0, 32'h0, rd, er, cy);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL range_word0 got %h err=%b exp 00000000 err=0", rd, er);
    end
    bus_idle();
  endtask

  task automatic test_misaligned();
    xfer(0, 1'b1, 32'h22, 32'h12345678, rd, er, cy);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_write got err=%b exp err=1", er);
    end
    xfer(0, 1'b0, 32'h20, 32'h0, rd, er, cy);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_readback got %h err=%b exp 00000000 err=0", rd, er);
    end
    bus_idle();
  endtask

  task automatic test_abort();
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    psel_v    = 3'b010;
    penable   = 1'b0;
    paddr     = 32'h8;
    pwrite    = 1'b1;
    pwdata    = 32'hA5A5A5A5;
    @(posedge clk); #1;
    psel_v  = '0;
    penable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #4;
      if (pready_v[1] !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_pready got asserted exp never asserted");
    end
    xfer(1, 1'b0, 32'h8, 32'h0, rd, er, cy);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || cy !== 4) begin
      errors++;
      $display("FAIL abort_readback got %h err=%b cycles=%0d exp 00000000 err=0 cycles=4", rd, er, cy);
    end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd [4];
    logic        wr_v   [4];
    logic [31:0] addr_v [4];
    logic [31:0] data_v [4];
    wr_v   = '{1'b1, 1'b1, 1'b0, 1'b0};
    addr_v = '{32'h0, 32'h4, 32'h0, 32'h4};
    data_v = '{32'h1, 32'h2, 32'h0, 32'h0};
    exp_rd = '{32'h0, 32'h0, 32'h1, 32'h2};
    for (int i = 0; i < 4; i++) begin
      xfer(2, wr_v[i], addr_v[i], data_v[i], rd, er, cy);
      checks++;
      if (rd !== exp_rd[i] || er !== 1'b0 || cy !== 2) begin
        errors++;
        $display("FAIL b2b_%0d got %h err=%b cycles=%0d exp %h err=0 cycles=2",
                 i, rd, er, cy, exp_rd[i]);
      end
    end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    psel_v  = 3'b001;
    penable = 1'b0;
    paddr   = 32'hC;
    pwrite  = 1'b1;
    pwdata  = 32'hFFFFFFFF;
    @(posedge clk); #1;
    penable = 1'b1;
    #4;
    checks++;
    if (pready_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_state got pready=%b exp 0", pready_v[0]);
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (pready_v[0] !== 1'b0 || pslverr_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_immediate got %b/%b exp 0/0", pready_v[0], pslverr_v[0]);
    end
    @(posedge clk); #4;
    checks++;
    if (pready_v[0] !== 1'b0 || pslverr_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_held got %b/%b exp 0/0", pready_v[0], pslverr_v[0]);
    end
    psel_v  = '0;
    penable = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    xfer(0, 1'b0, 32'hC, 32'h0, rd, er, cy);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL rst_readback got %h err=%b exp 00000000 err=0", rd, er);
    end
    xfer(0, 1'b1, 32'hC, 32'hCAFEF00D, rd, er, cy);
    xfer(0, 1'b0, 32'hC, 32'h0, rd, er, cy);
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0 || cy !== 3) begin
      errors++;
      $display("FAIL rst_after_xfer got %h err=%b cycles=%0d exp cafef00d err=0 cycles=3", rd, er, cy);
    end
    xfer(2, 1'b0, 32'h0, 32'h0, rd, er, cy);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL rst_clears_mem got %h exp 00000000", rd);
    end
    bus_idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_range();
    test_misaligned();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
